// File: rtl/frame_merge_arbiter.sv
// Frame-atomic round-robin merge of N_CH framed streams into one output stream,
// with stray-word flushing and a frame-length watchdog.
module frame_merge_arbiter #(
    parameter int unsigned N_CH                = 4,
    parameter int unsigned TDATA_WIDTH         = 256,
    parameter int unsigned HEADER_FOOTER_WIDTH = 64,
    parameter int unsigned HEAD_FOOT_ID_WIDTH  = 8,
    parameter logic [HEAD_FOOT_ID_WIDTH-1:0] HEADER_ID = 8'hFF,
    parameter logic [HEAD_FOOT_ID_WIDTH-1:0] FOOTER_ID = 8'h0F,
    parameter int unsigned MAX_FRAME_LENGTH    = 200,
    parameter int unsigned DROP_CNT_WIDTH      = 16
) (
    input  logic                          CLK,
    input  logic                          RESETN,
    input  logic [N_CH-1:0]               S_VALID,
    input  logic [N_CH*TDATA_WIDTH-1:0]   S_TDATA,
    output logic [N_CH-1:0]               S_READY,
    output logic                          M_VALID,
    output logic [TDATA_WIDTH-1:0]        M_TDATA,
    output logic                          M_TLAST,
    output logic [3:0]                    M_TUSER,
    input  logic                          M_READY,
    output logic                          FRAME_TIMEOUT,
    output logic [DROP_CNT_WIDTH-1:0]     DROP_COUNT,
    output logic                          BUSY
);

    localparam int unsigned GW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned CW = $clog2(MAX_FRAME_LENGTH + 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    logic [0:0]                state_q, state_d;
    logic [GW-1:0]             grant_q, grant_d;
    logic [GW-1:0]             last_grant_q, last_grant_d;
    logic [CW-1:0]             word_cnt_q, word_cnt_d;
    logic                      m_valid_q, m_valid_d;
    logic [TDATA_WIDTH-1:0]    m_tdata_q, m_tdata_d;
    logic                      m_tlast_q, m_tlast_d;
    logic [3:0]                m_tuser_q, m_tuser_d;
    logic                      timeout_q, timeout_d;
    logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;

    logic [TDATA_WIDTH-1:0]    ch_word [N_CH];
    logic [N_CH-1:0]           is_hdr;
    logic [N_CH-1:0]           req;
    logic [N_CH-1:0]           flush;
    logic [4:0]                flush_cnt;
    logic [DROP_CNT_WIDTH+4:0] drop_sum;
    logic [TDATA_WIDTH-1:0]    g_word;
    logic                      g_valid;
    logic                      g_is_ftr;
    logic                      load_ok;
    logic                      accept;
    logic                      last_word;
    logic [GW:0]               pick;

    // Returns {found, index} of the first requester after 'last' in round-robin order.
    function automatic logic [GW:0] pick_next(input logic [N_CH-1:0] r,
                                              input logic [GW-1:0]   last);
        logic [GW:0] res;
        int          idx;
        res = '0;
        for (int k = N_CH; k >= 1; k--) begin
            idx = (int'(last) + k) % int'(N_CH);
            if (r[idx]) res = {1'b1, GW'(idx)};
        end
        return res;
    endfunction

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            ch_word[i] = S_TDATA[i*TDATA_WIDTH +: TDATA_WIDTH];
            is_hdr[i]  = (ch_word[i][TDATA_WIDTH-1 -: HEAD_FOOT_ID_WIDTH] == HEADER_ID);
        end
    end

    always_comb begin
        req       = S_VALID & is_hdr;
        flush     = (state_q == ST_IDLE) ? (S_VALID & ~is_hdr) : '0;
        flush_cnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            flush_cnt = flush_cnt + 5'(flush[i]);
        end
        drop_sum  = {5'd0, drop_q} + {{DROP_CNT_WIDTH{1'b0}}, flush_cnt};
        pick      = pick_next(req, last_grant_q);
        g_word    = ch_word[grant_q];
        g_valid   = S_VALID[grant_q];
        g_is_ftr  = (g_word[HEAD_FOOT_ID_WIDTH-1:0] == FOOTER_ID) &&
                    (&g_word[TDATA_WIDTH-1:HEADER_FOOTER_WIDTH]);
        load_ok   = !m_valid_q || M_READY;
        accept    = (state_q == ST_STREAM) && g_valid && load_ok;
        last_word = g_is_ftr || (word_cnt_q == CW'(MAX_FRAME_LENGTH - 1));
    end

    // Gated by RESETN so the handshake is quiet for the whole reset assertion.
    always_comb begin
        S_READY = '0;
        if (state_q == ST_IDLE) begin
            S_READY = flush;
        end else begin
            S_READY[grant_q] = load_ok;
        end
        if (!RESETN) S_READY = '0;
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        word_cnt_d   = word_cnt_q;
        m_valid_d    = m_valid_q;
        m_tdata_d    = m_tdata_q;
        m_tlast_d    = m_tlast_q;
        m_tuser_d    = m_tuser_q;
        timeout_d    = 1'b0;
        drop_d       = drop_q;

        if (M_READY) begin
            m_valid_d = 1'b0;
            m_tlast_d = 1'b0;
        end

        if (state_q == ST_IDLE) begin
            drop_d = (|drop_sum[DROP_CNT_WIDTH+4:DROP_CNT_WIDTH]) ?
                     {DROP_CNT_WIDTH{1'b1}} : drop_sum[DROP_CNT_WIDTH-1:0];
            if (pick[GW]) begin
                grant_d      = pick[GW-1:0];
                last_grant_d = pick[GW-1:0];
                word_cnt_d   = '0;
                state_d      = ST_STREAM;
            end
        end else if (accept) begin
            m_valid_d  = 1'b1;
            m_tdata_d  = g_word;
            m_tuser_d  = 4'(grant_q);
            m_tlast_d  = last_word;
            timeout_d  = !g_is_ftr && last_word;
            word_cnt_d = word_cnt_q + CW'(1);
            if (last_word) state_d = ST_IDLE;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(N_CH - 1);
            word_cnt_q   <= '0;
            m_valid_q    <= 1'b0;
            m_tdata_q    <= '0;
            m_tlast_q    <= 1'b0;
            m_tuser_q    <= '0;
            timeout_q    <= 1'b0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            word_cnt_q   <= word_cnt_d;
            m_valid_q    <= m_valid_d;
            m_tdata_q    <= m_tdata_d;
            m_tlast_q    <= m_tlast_d;
            m_tuser_q    <= m_tuser_d;
            timeout_q    <= timeout_d;
            drop_q       <= drop_d;
        end
    end

    assign M_VALID       = m_valid_q;
    assign M_TDATA       = m_tdata_q;
    assign M_TLAST       = m_tlast_q;
    assign M_TUSER       = m_tuser_q;
    assign FRAME_TIMEOUT = timeout_q;
    assign DROP_COUNT    = drop_q;
    assign BUSY          = (state_q == ST_STREAM);

endmodule
